mul_unit: RTL

Iterative 32×32 multiplier execution unit for the v11 MCU datapath. It sits between the register file read ports and its write port. It consumes Rm/Rs (and Rn for MLA) read values, computes the low 32 bits of the product over a fixed 32-cycle shift-add sequence, then issues a single write-back request (index, data, enable) for the core to mux into the register file write port. The core stalls on `busy`.

---
 rtl/mul_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mul_unit.sv
// mul_unit: iterative 32x32 multiplier execution unit (low 32 bits of product).
// A fixed 32-step shift-add sequence produces the result. The unit then issues
// one write-back request (we/wa/wd) for the core to mux into the register file.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   start            request a new operation (sampled in IDLE or DONE only)
//   op_a, op_b       multiplicand (Rm) and multiplier (Rs)
//   op_acc, acc_en   accumulate operand (Rn) and MLA select
//   rd_idx           destination register index
//   busy             high while the shift-add sequence runs
//   done             one-cycle pulse in the write-back cycle
//   we, wa, wd       write-back enable/index/data; wa/wd hold between results
//   n_flag, z_flag   sign and zero of the last completed result
//
// Build option: define MUL_MLA_EN to honour acc_en/op_acc (MLA). Without it
// the unit is MUL-only and those ports are left unused.
module mul_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] op_acc,
    input  logic        acc_en,
    input  logic [3:0]  rd_idx,
    output logic        busy,
    output logic        done,
    output logic        we,
    output logic [3:0]  wa,
    output logic [31:0] wd,
    output logic        n_flag,
    output logic        z_flag
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] acc_reg;
    logic [3:0]  rd_reg;
    logic [4:0]  cnt;

    logic [31:0] acc_sum;
    logic [31:0] acc_init;

    // Partial-product step: add the shifted multiplicand when the current
    // multiplier bit is set. Wraps mod 2^32, so signed and unsigned agree.
    always_comb begin
        acc_sum = acc_reg;
        if (b_reg[0]) begin
            acc_sum = acc_reg + a_reg;
        end
    end

`ifdef MUL_MLA_EN
    assign acc_init = acc_en ? op_acc : 32'd0;
`else
    logic unused_mla;
    assign acc_init   = 32'd0;
    assign unused_mla = ^{acc_en, op_acc};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
            rd_reg  <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            we      <= 1'b0;
            wa      <= '0;
            wd      <= '0;
            n_flag  <= 1'b0;
            z_flag  <= 1'b0;
        end else begin
            // done/we are single-cycle pulses; only the RUN->DONE step sets them.
            done <= 1'b0;
            we   <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // DONE accepts start too, giving back-to-back operations.
                    if (start) begin
                        a_reg   <= op_a;
                        b_reg   <= op_b;
                        acc_reg <= acc_init;
                        rd_reg  <= rd_idx;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // No early exit: always 32 steps, so latency is fixed.
                    acc_reg <= acc_sum;
                    a_reg   <= a_reg << 1;
                    b_reg   <= b_reg >> 1;
                    cnt     <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        // Write-back outputs are registered from the final step so
                        // they are valid for the whole DONE cycle.
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        we     <= (rd_reg != 4'd15);
                        wa     <= rd_reg;
                        wd     <= acc_sum;
                        n_flag <= acc_sum[31];
                        z_flag <= (acc_sum == 32'd0);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
